// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issues one FP op at a time to a combinational FPU and holds its inputs
// stable for a per-class latency. It then captures the result and returns it over a
// valid/ready response channel.
module fpu_issue_ctrl #(
  parameter int unsigned BUS_WIDTH = 64,
  parameter int unsigned OP_LEN    = 6,
  parameter int unsigned TAG_W     = 5,
  parameter int unsigned LAT_FAST  = 1,
  parameter int unsigned LAT_ADD   = 2,
  parameter int unsigned LAT_MUL   = 3,
  parameter int unsigned LAT_DIV   = 8,
  parameter int unsigned LAT_SQRT  = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [BUS_WIDTH-1:0] req_in1,
  input  logic [BUS_WIDTH-1:0] req_in2,
  input  logic [OP_LEN-1:0]    req_op,
  input  logic [TAG_W-1:0]     req_tag,
  output logic [BUS_WIDTH-1:0] fpu_in1,
  output logic [BUS_WIDTH-1:0] fpu_in2,
  output logic [OP_LEN-1:0]    fpu_op,
  input  logic [BUS_WIDTH-1:0] fpu_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BUS_WIDTH-1:0] rsp_data,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic                 rsp_illegal,
  output logic                 busy,
  output logic [31:0]          op_count
);

  localparam int unsigned LAT_MAX_A = (LAT_FAST > LAT_ADD) ? LAT_FAST : LAT_ADD;
  localparam int unsigned LAT_MAX_B = (LAT_MUL > LAT_DIV) ? LAT_MUL : LAT_DIV;
  localparam int unsigned LAT_MAX_C = (LAT_MAX_A > LAT_MAX_B) ? LAT_MAX_A : LAT_MAX_B;
  localparam int unsigned LAT_MAX   = (LAT_MAX_C > LAT_SQRT) ? LAT_MAX_C : LAT_SQRT;
  // Counter only has to hold LAT_MAX-1.
  localparam int unsigned CNT_W     = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  localparam logic [BUS_WIDTH-1:0] CANON_NAN = (BUS_WIDTH == 32) ?
                                               BUS_WIDTH'(32'h7FC0_0000) :
                                               BUS_WIDTH'(64'h7FF8_0000_0000_0000);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0] fpu_in1_q, fpu_in1_d;
  logic [BUS_WIDTH-1:0] fpu_in2_q, fpu_in2_d;
  logic [OP_LEN-1:0]    fpu_op_q, fpu_op_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [BUS_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0]     rsp_tag_q, rsp_tag_d;
  logic                 rsp_illegal_q, rsp_illegal_d;
  logic [31:0]          op_count_q, op_count_d;

  logic [31:0]          op_v;
  logic                 dec_illegal;
  logic [CNT_W-1:0]     dec_cnt;

  // Decode the incoming op code into its latency class (as cnt preload) and legality.
  always_comb begin
    op_v        = 32'(req_op);
    dec_illegal = 1'b0;
    dec_cnt     = CNT_W'(LAT_FAST - 1);
    if (op_v <= 32'd3) begin
      dec_cnt = CNT_W'(LAT_ADD - 1);
    end else if (op_v <= 32'd5) begin
      dec_cnt = CNT_W'(LAT_MUL - 1);
    end else if (op_v <= 32'd7) begin
      dec_cnt = CNT_W'(LAT_DIV - 1);
    end else if (op_v <= 32'd9) begin
      dec_cnt = CNT_W'(LAT_SQRT - 1);
    end else if (op_v == 32'd32 || op_v == 32'd33) begin
      dec_cnt = CNT_W'(LAT_FAST - 1);
    end else if (op_v >= 32'd34 && op_v <= 32'd39 && BUS_WIDTH != 32) begin
      dec_cnt = CNT_W'(LAT_ADD - 1);
    end else begin
      // Unlisted codes, and fcvt on a 32-bit datapath, take the fast path and return NaN.
      dec_illegal = 1'b1;
      dec_cnt     = CNT_W'(LAT_FAST - 1);
    end
  end

  // Next-state logic for the IDLE -> EXEC -> DONE sequence; flush always wins.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fpu_in1_d     = fpu_in1_q;
    fpu_in2_d     = fpu_in2_q;
    fpu_op_d      = fpu_op_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_tag_d     = rsp_tag_q;
    rsp_illegal_d = rsp_illegal_q;
    op_count_d    = op_count_q;
    unique case (state_q)
      StIdle: begin
        if (!flush && req_valid) begin
          fpu_in1_d     = req_in1;
          fpu_in2_d     = req_in2;
          fpu_op_d      = req_op;
          rsp_tag_d     = req_tag;
          rsp_illegal_d = dec_illegal;
          cnt_d         = dec_cnt;
          state_d       = StExec;
        end
      end
      StExec: begin
        if (flush) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          rsp_data_d  = rsp_illegal_q ? CANON_NAN : fpu_out;
          rsp_valid_d = 1'b1;
          state_d     = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        if (flush) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 32'd1;
          state_d     = StIdle;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = StIdle;
      end
    endcase
  end

  // State and output registers, cleared immediately by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      fpu_in1_q     <= '0;
      fpu_in2_q     <= '0;
      fpu_op_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_tag_q     <= '0;
      rsp_illegal_q <= 1'b0;
      op_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fpu_in1_q     <= fpu_in1_d;
      fpu_in2_q     <= fpu_in2_d;
      fpu_op_q      <= fpu_op_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_tag_q     <= rsp_tag_d;
      rsp_illegal_q <= rsp_illegal_d;
      op_count_q    <= op_count_d;
    end
  end

  // req_ready drops under flush so a flushed cycle never looks like a handshake.
  assign req_ready   = (state_q == StIdle) && !flush;
  assign busy        = (state_q != StIdle);
  assign fpu_in1     = fpu_in1_q;
  assign fpu_in2     = fpu_in2_q;
  assign fpu_op      = fpu_op_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_tag     = rsp_tag_q;
  assign rsp_illegal = rsp_illegal_q;
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: randomized and directed checks of fpu_issue_ctrl against a
// transaction-level model (accept time + class latency, pending result, handshake count).
module tb_fpu_issue_ctrl;

  localparam int unsigned LAT_FAST = 1;
  localparam int unsigned LAT_ADD  = 2;
  localparam int unsigned LAT_MUL  = 3;
  localparam int unsigned LAT_DIV  = 8;
  localparam int unsigned LAT_SQRT = 10;
  localparam logic [63:0] NAN64    = 64'h7FF8_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_in1, req_in2;
  logic [5:0]  req_op;
  logic [4:0]  req_tag;
  logic [63:0] fpu_in1, fpu_in2;
  logic [5:0]  fpu_op;
  logic [63:0] fpu_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic [4:0]  rsp_tag;
  logic        rsp_illegal;
  logic        busy;
  logic [31:0] op_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Transaction model state
  bit          m_active;
  longint      edges;
  longint      m_due;
  logic [63:0] m_fin1, m_fin2, m_data;
  logic [5:0]  m_fop;
  logic [4:0]  m_tag;
  logic        m_ill;
  logic [31:0] m_count;

  fpu_issue_ctrl #(
    .BUS_WIDTH(64), .OP_LEN(6), .TAG_W(5), .LAT_FAST(LAT_FAST), .LAT_ADD(LAT_ADD),
    .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV), .LAT_SQRT(LAT_SQRT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_op(req_op), .req_tag(req_tag),
    .fpu_in1(fpu_in1), .fpu_in2(fpu_in2), .fpu_op(fpu_op), .fpu_out(fpu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_illegal(rsp_illegal), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Stand-in combinational FPU: real add/div for the ops used in directed tests.
  function automatic logic [63:0] toy_fpu(input logic [63:0] a, input logic [63:0] b,
                                          input logic [5:0] op);
    real ra, rb;
    ra = $bitstoreal(a);
    rb = $bitstoreal(b);
    if (op == 6'd0) return $realtobits(ra + rb);
    if (op == 6'd6) return $realtobits(ra / rb);
    return a ^ {b[31:0], b[63:32]} ^ {58'd0, op};
  endfunction

  assign fpu_out = toy_fpu(fpu_in1, fpu_in2, fpu_op);

  function automatic bit op_illegal(input logic [5:0] op);
    return !((op <= 6'd9) || (op >= 6'd32 && op <= 6'd39));
  endfunction

  function automatic int unsigned op_lat(input logic [5:0] op);
    if (op_illegal(op)) return LAT_FAST;
    if (op <= 6'd3) return LAT_ADD;
    if (op <= 6'd5) return LAT_MUL;
    if (op <= 6'd7) return LAT_DIV;
    if (op <= 6'd9) return LAT_SQRT;
    if (op <= 6'd33) return LAT_FAST;
    return LAT_ADD;
  endfunction

  function automatic logic [63:0] rand_dbl();
    logic [63:0] r;
    r = {$urandom, $urandom};
    r[63] = 1'b0;
    r[62:52] = 11'(1020 + $urandom_range(0, 10));
    return r;
  endfunction

  function automatic logic [5:0] rand_op();
    int unsigned p;
    p = $urandom_range(0, 99);
    if (p < 40) return 6'($urandom_range(0, 9));
    if (p < 75) return 6'($urandom_range(32, 39));
    if (p < 85) return 6'($urandom_range(10, 15));
    return 6'($urandom_range(40, 63));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_due    = 0;
    m_fin1   = '0;
    m_fin2   = '0;
    m_fop    = '0;
    m_data   = '0;
    m_tag    = '0;
    m_ill    = 1'b0;
    m_count  = '0;
  endtask

  // One clock edge of the model: accept, flush, or response handshake.
  task automatic model_step();
    if (!rst_n) return;
    if (!m_active) begin
      if (req_valid && !flush) begin
        m_active = 1'b1;
        m_due    = edges + 1 + longint'(op_lat(req_op));
        m_fin1   = req_in1;
        m_fin2   = req_in2;
        m_fop    = req_op;
        m_tag    = req_tag;
        m_ill    = op_illegal(req_op);
        m_data   = m_ill ? NAN64 : toy_fpu(req_in1, req_in2, req_op);
      end
    end else if (flush) begin
      m_active = 1'b0;
    end else if (edges >= m_due && rsp_ready) begin
      m_active = 1'b0;
      m_count  = m_count + 32'd1;
    end
    edges++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive_req(input logic [63:0] a, input logic [63:0] b, input logic [5:0] op,
                           input logic [4:0] tag);
    req_valid = 1'b1;
    req_in1   = a;
    req_in2   = b;
    req_op    = op;
    req_tag   = tag;
  endtask

  // Mid-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_active);
      chk("req_ready", req_ready, !m_active && !flush);
      chk("op_count", op_count, m_count);
      chk("fpu_in1", fpu_in1, m_fin1);
      chk("fpu_in2", fpu_in2, m_fin2);
      chk("fpu_op", fpu_op, m_fop);
      chk("rsp_valid", rsp_valid, m_active && (edges >= m_due));
      if (m_active && (edges >= m_due)) begin
        chk("rsp_data", rsp_data, m_data);
        chk("rsp_tag", rsp_tag, m_tag);
        chk("rsp_illegal", rsp_illegal, m_ill);
      end
    end
  end

  initial begin
    logic [63:0] held;
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_in1 = '0; req_in2 = '0; req_op = '0; req_tag = '0;
    edges = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Reset state
    @(negedge clk);
    chk("reset req_ready", req_ready, 1);
    chk("reset busy", busy, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_data", rsp_data, 0);
    chk("reset op_count", op_count, 0);
    chk("reset fpu_in1", fpu_in1, 0);

    // fadd.d 1.0 + 2.0, then 5 cycles of backpressure
    drive_req(64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 6'b000000, 5'd3);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("fadd after accept valid", rsp_valid, 0);
    tick();
    @(negedge clk);
    chk("fadd edge1 valid", rsp_valid, 0);
    tick();
    @(negedge clk);
    chk("fadd edge2 valid", rsp_valid, 1);
    chk("fadd data", rsp_data, 64'h4008_0000_0000_0000);
    chk("fadd tag", rsp_tag, 5'd3);
    held = rsp_data;
    repeat (5) begin
      tick();
      @(negedge clk);
      chk("bp data stable", rsp_data, held);
      chk("bp req_ready", req_ready, 0);
      chk("bp op_count", op_count, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp release op_count", op_count, 1);
    chk("bp release valid", rsp_valid, 0);

    // fdiv.d 6.0 / 2.0: result exactly 8 edges after accept
    drive_req(64'h4018_0000_0000_0000, 64'h4000_0000_0000_0000, 6'b000110, 5'd7);
    tick();
    req_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      @(negedge clk);
      chk("fdiv valid timing", rsp_valid, (i == 8));
      if (i < 8) chk("fdiv req_ready", req_ready, 0);
    end
    chk("fdiv data", rsp_data, 64'h4008_0000_0000_0000);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Illegal op: fast path, canonical NaN
    drive_req(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 6'b001010, 5'd9);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("illegal after accept valid", rsp_valid, 0);
    tick();
    @(negedge clk);
    chk("illegal valid", rsp_valid, 1);
    chk("illegal data", rsp_data, NAN64);
    chk("illegal flag", rsp_illegal, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("illegal op_count", op_count, 3);

    // Async reset in the middle of fsqrt.d
    drive_req(64'h4010_0000_0000_0000, 64'h0, 6'b001000, 5'd1);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst busy", busy, 0);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst op_count", op_count, 0);
    chk("rst fpu_in1", fpu_in1, 0);
    chk("rst fpu_op", fpu_op, 0);
    tick();
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (12) begin
      tick();
      @(negedge clk);
      chk("post-rst no rsp", rsp_valid, 0);
    end
    rsp_ready = 1'b0;

    // Flush in DONE together with rsp_ready: no count
    drive_req(64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 6'b100000, 5'd5);
    tick();
    req_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("flush-done valid before", rsp_valid, 1);
    flush = 1'b1;
    rsp_ready = 1'b1;
    tick();
    flush = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("flush-done valid", rsp_valid, 0);
    chk("flush-done busy", busy, 0);
    chk("flush-done op_count", op_count, 0);

    // Flush in IDLE blocks acceptance
    drive_req(64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 6'b000000, 5'd2);
    flush = 1'b1;
    @(negedge clk);
    chk("flush-idle req_ready", req_ready, 0);
    tick();
    @(negedge clk);
    chk("flush-idle busy", busy, 0);
    flush = 1'b0;
    req_valid = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      req_valid = ($urandom_range(0, 9) < 7);
      req_in1   = rand_dbl();
      req_in2   = rand_dbl();
      req_op    = rand_op();
      req_tag   = 5'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 4);
    end
    req_valid = 1'b0;
    flush     = 1'b0;
    rsp_ready = 1'b1;
    repeat (15) tick();
    @(negedge clk);
    chk("drain idle", busy, 0);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
